// File: rtl/key_event_fifo.sv
// Four-key debouncer feeding a small first-word-fall-through event FIFO.
// Every debounced press or release becomes a 3-bit {press, key_idx} event.
`timescale 1ns/1ps
module key_event_fifo #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [3:0] key_n,
    output logic [3:0] key_state,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [2:0] evt_data,
    output logic [4:0] evt_count,
    output logic       overflow,
    input  logic       overflow_clr
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]  DEPTH    = 5'(FIFO_DEPTH);

    logic [3:0]  sync1_reg, sync2_reg;
    logic [3:0]  key_state_reg;
    logic [23:0] cnt_reg [4];
    logic [3:0]  pending_reg;
    logic [3:0]  differ, toggle;

    logic [2:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [4:0]    count_reg;
    logic          overflow_reg;

    logic       sel_valid;
    logic [1:0] sel_idx;
    logic [3:0] sel_onehot;
    logic       pop, full, push;
    logic [2:0] push_data;

    // Synchronized level is active-low; compare it against the debounced pressed level.
    for (genvar gi = 0; gi < 4; gi++) begin : g_key
        assign differ[gi] = (~sync2_reg[gi]) != key_state_reg[gi];
        assign toggle[gi] = differ[gi] && (cnt_reg[gi] == CNT_LAST);
    end

    always_comb begin
        sel_valid  = 1'b0;
        sel_idx    = 2'd0;
        sel_onehot = 4'b0000;
        for (int i = 3; i >= 0; i--) begin
            if (pending_reg[i]) begin
                sel_valid  = 1'b1;
                sel_idx    = 2'(i);
                sel_onehot = 4'b0001 << i;
            end
        end
    end

    assign push_data = {key_state_reg[sel_idx], sel_idx};
    assign pop       = (count_reg != 5'd0) && evt_ready;
    assign full      = (count_reg == DEPTH);
    // A full FIFO still takes the event if the head leaves on the same edge.
    assign push      = sel_valid && (!full || pop);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_reg     <= 4'hF;
            sync2_reg     <= 4'hF;
            key_state_reg <= 4'h0;
            pending_reg   <= 4'h0;
            for (int i = 0; i < 4; i++) cnt_reg[i] <= '0;
        end else begin
            sync1_reg   <= key_n;
            sync2_reg   <= sync1_reg;
            // Selected key is cleared even if its event is dropped; a new toggle wins.
            pending_reg <= (pending_reg & ~sel_onehot) | toggle;
            for (int i = 0; i < 4; i++) begin
                if (!differ[i] || toggle[i]) begin
                    cnt_reg[i] <= '0;
                end else begin
                    cnt_reg[i] <= cnt_reg[i] + 24'd1;
                end
                if (toggle[i]) key_state_reg[i] <= ~key_state_reg[i];
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push) mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= 5'd0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 5'd1;
                2'b01:   count_reg <= count_reg - 5'd1;
                default: count_reg <= count_reg;
            endcase
            if (sel_valid && full && !pop) begin
                overflow_reg <= 1'b1;
            end else if (overflow_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign key_state = key_state_reg;
    assign evt_valid = (count_reg != 5'd0);
    assign evt_data  = evt_valid ? mem[rd_ptr_reg] : 3'b000;
    assign evt_count = count_reg;
    assign overflow  = overflow_reg;
endmodule

// File: tb/tb_key_event_fifo.sv
// Directed bench for key_event_fifo with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
`timescale 1ns/1ps
module tb_key_event_fifo;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] key_n;
    logic [3:0] key_state;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_data;
    logic [4:0] evt_count;
    logic       overflow;
    logic       overflow_clr;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    key_event_fifo #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
        .clk_clk      (clk),
        .reset_reset_n(reset_n),
        .key_n        (key_n),
        .key_state    (key_state),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_data     (evt_data),
        .evt_count    (evt_count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    typedef struct {
        logic [3:0] kn;
        logic       rdy;
        logic [3:0] ks;
        logic       v;
        logic [2:0] d;
        logic [4:0] c;
        logic       ov;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(logic [3:0] kn, logic rdy, logic [3:0] ks,
                                logic v, logic [2:0] d, logic [4:0] c, logic ov);
        vec_t r;
        r.kn = kn; r.rdy = rdy; r.ks = ks; r.v = v; r.d = d; r.c = c; r.ov = ov;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        key_n        = 4'hF;
        evt_ready    = 1'b0;
        overflow_clr = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_ks(input int k, input logic val, input string name);
        for (int i = 0; i < 20 && key_state[k] !== val; i++) tick();
        check(name, key_state[k], val);
    endtask

    always @(posedge clk) begin
        if (reset_n && evt_valid && evt_ready)
            $display("pop: data=%b count=%0d", evt_data, evt_count);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Press of key 2, pop, release of key 2, pop: one row per clock edge.
        for (int i = 0; i < 5; i++) tbl[i] = mk(4'b1011, 0, 4'b0000, 0, 3'b000, 0, 0);
        tbl[5]  = mk(4'b1011, 0, 4'b0100, 0, 3'b000, 0, 0);
        tbl[6]  = mk(4'b1011, 0, 4'b0100, 1, 3'b110, 1, 0);
        tbl[7]  = mk(4'b1011, 0, 4'b0100, 1, 3'b110, 1, 0);
        tbl[8]  = mk(4'b1011, 1, 4'b0100, 0, 3'b000, 0, 0);
        for (int i = 9; i < 14; i++) tbl[i] = mk(4'b1111, 0, 4'b0100, 0, 3'b000, 0, 0);
        tbl[14] = mk(4'b1111, 0, 4'b0000, 0, 3'b000, 0, 0);
        tbl[15] = mk(4'b1111, 0, 4'b0000, 1, 3'b010, 1, 0);
        tbl[16] = mk(4'b1111, 1, 4'b0000, 0, 3'b000, 0, 0);

        do_reset();
        check("reset ks", key_state, 4'b0000);
        check("reset valid", evt_valid, 1'b0);
        check("reset count", evt_count, 5'd0);
        check("reset overflow", overflow, 1'b0);

        for (int i = 0; i < 17; i++) begin
            key_n     = tbl[i].kn;
            evt_ready = tbl[i].rdy;
            tick();
            check($sformatf("vec%0d ks", i), key_state, tbl[i].ks);
            check($sformatf("vec%0d valid", i), evt_valid, tbl[i].v);
            check($sformatf("vec%0d data", i), evt_data, tbl[i].d);
            check($sformatf("vec%0d count", i), evt_count, tbl[i].c);
            check($sformatf("vec%0d overflow", i), overflow, tbl[i].ov);
        end

        // Three-cycle glitch on key 1 must vanish.
        do_reset();
        key_n = 4'b1101;
        repeat (3) tick();
        key_n = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("glitch cyc%0d", i), {key_state, evt_valid}, 5'b00000);
        end

        // Keys 3 and 0 together: ascending order, one per cycle.
        do_reset();
        key_n     = 4'b0110;
        evt_ready = 1'b1;
        repeat (6) tick();
        check("dual ks", key_state, 4'b1001);
        check("dual valid early", evt_valid, 1'b0);
        tick();
        check("dual first", evt_data, 3'b100);
        check("dual first count", evt_count, 5'd1);
        tick();
        check("dual second", evt_data, 3'b111);
        check("dual second count", evt_count, 5'd1);
        tick();
        check("dual drained", evt_count, 5'd0);
        evt_ready = 1'b0;

        // Five events into a depth-4 FIFO.
        do_reset();
        key_n = 4'b1000;
        wait_ks(2, 1'b1, "ovf press");
        repeat (4) tick();
        check("ovf three", evt_count, 5'd3);
        key_n = 4'b1011;
        wait_ks(0, 1'b0, "ovf release");
        repeat (4) tick();
        check("ovf count", evt_count, 5'd4);
        check("ovf flag", overflow, 1'b1);
        check("ovf head", evt_data, 3'b100);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("ovf cleared", overflow, 1'b0);
        check("ovf count kept", evt_count, 5'd4);

        // Drop and clear on the same edge: set wins, contents untouched.
        key_n = 4'b0011;
        wait_ks(3, 1'b1, "setwin press");
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("setwin flag", overflow, 1'b1);
        check("setwin count", evt_count, 5'd4);
        check("setwin head", evt_data, 3'b100);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("setwin cleared", overflow, 1'b0);

        // Full FIFO with pop and push on the same edge.
        key_n = 4'b1011;
        wait_ks(3, 1'b0, "fullpp release");
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("fullpp count", evt_count, 5'd4);
        check("fullpp overflow", overflow, 1'b0);
        check("fullpp head", evt_data, 3'b101);

        // Asynchronous reset with three entries queued.
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("pre-reset count", evt_count, 5'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("async count", evt_count, 5'd0);
        check("async valid", evt_valid, 1'b0);
        check("async ks", key_state, 4'b0000);
        check("async data", evt_data, 3'b000);
        @(negedge clk);
        reset_n = 1'b1;

        // Key 2 still held: fresh press after normal latency.
        repeat (6) @(posedge clk);
        #1;
        check("held ks", key_state, 4'b0100);
        check("held valid early", evt_valid, 1'b0);
        tick();
        check("held valid", evt_valid, 1'b1);
        check("held data", evt_data, 3'b110);
        check("held count", evt_count, 5'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/key_event_fifo.md
KEY_EVENT_FIFO -- requirements
Module: key_event_fifo

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz), legal range 4..2^24-1.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, a power of two in the range 2..16.
REQ-003 SHALL have port clk_clk, input, 1 bit; the single clock, with every flop on its rising edge.
REQ-004 SHALL have port reset_reset_n, input, 1 bit; asynchronous, active-low reset.
REQ-005 SHALL have port key_n, input, 4 bits; raw push-buttons, active-low, asynchronous to clk_clk.
REQ-006 SHALL have port key_state, output, 4 bits; debounced level, 1 = pressed.
REQ-007 SHALL have port evt_valid, output, 1 bit; FIFO head is valid.
REQ-008 SHALL have port evt_ready, input, 1 bit; consumer (Nios PIO read strobe) accepts the head.
REQ-009 SHALL have port evt_data, output, 3 bits; {press, key_idx[1:0]}, where press=1 means press and press=0 means release.
REQ-010 SHALL have port evt_count, output, 5 bits; number of entries currently in the FIFO.
REQ-011 SHALL have port overflow, output, 1 bit; sticky flag for a dropped event.
REQ-012 SHALL have port overflow_clr, input, 1 bit; synchronous clear for overflow.

Function
REQ-013 SHALL pass each key_n bit through a 2-flop synchronizer; sync flops reset to 1 (released).
REQ-014 SHALL keep a per-key 24-bit counter that increments every cycle the synchronized level differs from the stable level, and resets to 0 whenever they match.
REQ-015 SHALL, when a key's counter equals DEBOUNCE_CYCLES-1 and the levels still differ, at the next edge toggle that key_state bit, zero the counter and set that key's pending flag.
REQ-016 SHALL emit no event for any input pulse shorter than DEBOUNCE_CYCLES synchronized cycles.
REQ-017 SHALL select, each cycle, the lowest-index key with pending set and push {key_state[idx], idx} into the FIFO at the next edge, clearing that key's pending flag.
REQ-018 SHALL service simultaneous pending keys one per cycle in ascending index order.
REQ-019 SHALL give a latency of 3+DEBOUNCE_CYCLES edges from the first key_n change to the FIFO write; evt_valid rises on that same write edge.
REQ-020 SHALL be a first-word-fall-through FIFO: evt_data shows the head whenever evt_valid=1, and evt_data=3'b000 when the FIFO is empty.
REQ-021 SHALL pop on an edge where evt_valid && evt_ready; evt_ready while empty SHALL be ignored, with no underflow and no count change.
REQ-022 SHALL, on a push with no pop, increment evt_count; on a pop with no push, decrement it; on push and pop in the same cycle, leave it unchanged.
REQ-023 SHALL, when full, accept a push only if a pop occurs in the same cycle; otherwise the push is dropped, pending is still cleared, and overflow is set to 1.
REQ-024 SHALL wrap the read and write pointers modulo FIFO_DEPTH; evt_count ranges 0..FIFO_DEPTH.
REQ-025 SHALL clear overflow on overflow_clr; a simultaneous drop and overflow_clr SHALL leave overflow=1 (set wins).
REQ-026 SHALL leave FIFO contents unchanged when key_state changes while the FIFO is full; only the event is lost.

Reset
REQ-027 SHALL, while reset_reset_n=0, immediately force: sync flops 1, key_state 0, counters 0, pending 0, pointers 0, evt_count 0, evt_valid 0, evt_data 0, overflow 0.
REQ-028 SHALL, on reset asserted mid-debounce or with a non-empty FIFO, discard all state; no event from before reset is delivered.
REQ-029 SHALL, after reset release with a key held low, debounce it as a new press and emit a press event after the normal latency.

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4)
REQ-030 SHALL check: key_n[2] held low from cycle 0 -> key_state[2]=1 after edge 6; evt_valid=1, evt_data=3'b110 and evt_count=1 after edge 7.
REQ-031 SHALL check: key_n[1] low for 3 cycles then high -> key_state stays 0 and evt_valid stays 0.
REQ-032 SHALL check: key_n[3] and key_n[0] drop in the same cycle, evt_ready=1 -> events 3'b100 then 3'b111 on consecutive cycles.
REQ-033 SHALL check: 5 press/release events with evt_ready=0 -> evt_count=4, overflow=1, head is the first event; then overflow_clr pulse -> overflow=0.
REQ-034 SHALL check: FIFO full, pop and push in the same cycle -> evt_count stays 4 and overflow stays 0.
REQ-035 SHALL check: reset_reset_n pulsed low with evt_count=3 -> evt_count=0, evt_valid=0 and key_state=0 with no clock edge required.
